// File: rtl/mmio_timer_pkg.sv
// Shared register map, CTRL field positions and bus helpers for the memory-mapped timer.
package mmio_timer_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COUNT   = 2'd1;
    localparam logic [1:0] REG_COMPARE = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int CTRL_PSC_LSB     = 8;

    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_t;

    // Lane-wise store merge: lanes with be[i]=0 keep the old byte.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++)
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock by PRESCALE+1; TICK pulses on the cycle the divider rolls over.
module timer_prescaler #(
    parameter int PSC_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [PSC_W-1:0] PRESCALE,
    output logic             TICK
);

    logic [PSC_W-1:0] psc_cnt;

    assign TICK = EN && (psc_cnt == PRESCALE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            psc_cnt <= '0;
        else if (!EN || TICK)
            psc_cnt <= '0;
        else
            psc_cnt <= psc_cnt + 1'b1;
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer: 16-byte register window, prescaled counter,
// sticky compare match and level interrupt.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          PSC_W     = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CEN,
    input  logic        WEN,
    input  logic [31:0] ADDR,
    input  logic [3:0]  BYTE_SEL,
    input  logic [31:0] SDATA,
    output logic [31:0] LDATA,
    output logic        IRQ
);

    ctrl_t            ctrl;
    logic [PSC_W-1:0] prescale;
    logic [31:0]      count;
    logic [31:0]      compare;
    logic             match;

    logic        sel, wr, rd;
    logic [1:0]  idx;
    logic        wr_ctrl, wr_count, wr_compare, w1c;
    logic [31:0] ctrl_word, ctrl_wdata;
    logic        en_eff, tick, hit, match_set;
    logic        unused_bits;

    assign sel = CEN && (ADDR[31:4] == BASE_ADDR[31:4]);
    assign idx = ADDR[3:2];
    assign wr  = sel && WEN;
    assign rd  = sel && !WEN;

    assign wr_ctrl    = wr && (idx == REG_CTRL);
    assign wr_count   = wr && (idx == REG_COUNT);
    assign wr_compare = wr && (idx == REG_COMPARE);
    assign w1c        = wr && (idx == REG_STATUS) && BYTE_SEL[0] && SDATA[0];

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_EN]          = ctrl.en;
        ctrl_word[CTRL_AUTO_RELOAD] = ctrl.auto_reload;
        ctrl_word[CTRL_IRQ_EN]      = ctrl.irq_en;
        ctrl_word[CTRL_PSC_LSB +: PSC_W] = prescale;
    end

    assign ctrl_wdata = byte_merge(ctrl_word, SDATA, BYTE_SEL);

    // A store that clears EN must stop the prescaler on that same edge.
    assign en_eff = ctrl.en && !(wr_ctrl && !ctrl_wdata[CTRL_EN]);

    timer_prescaler #(.PSC_W(PSC_W)) u_psc (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (en_eff),
        .PRESCALE (prescale),
        .TICK     (tick)
    );

    // A COUNT store suppresses both the increment and the compare in its cycle.
    assign hit       = (count == compare);
    assign match_set = tick && !wr_count && hit;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ctrl     <= '0;
            prescale <= '0;
            count    <= '0;
            compare  <= '0;
            match    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl.en          <= ctrl_wdata[CTRL_EN];
                ctrl.auto_reload <= ctrl_wdata[CTRL_AUTO_RELOAD];
                ctrl.irq_en      <= ctrl_wdata[CTRL_IRQ_EN];
                prescale         <= ctrl_wdata[CTRL_PSC_LSB +: PSC_W];
            end
            if (wr_compare)
                compare <= byte_merge(compare, SDATA, BYTE_SEL);
            if (wr_count)
                count <= byte_merge(count, SDATA, BYTE_SEL);
            else if (tick)
                count <= (hit && ctrl.auto_reload) ? 32'd0 : count + 32'd1;
            if (match_set)
                match <= 1'b1;
            else if (w1c)
                match <= 1'b0;
        end
    end

    always_comb begin
        LDATA = '0;
        if (rd) begin
            case (idx)
                REG_CTRL:    LDATA = ctrl_word;
                REG_COUNT:   LDATA = count;
                REG_COMPARE: LDATA = compare;
                default:     LDATA = {31'd0, match};
            endcase
        end
    end

    assign IRQ = match && ctrl.irq_en;

    assign unused_bits = ^{ADDR[1:0], ctrl_wdata};

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: register access, prescaled counting, match/W1C races, wrap and reset.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_CNT  = BASE + 32'h4;
    localparam logic [31:0] A_CMP  = BASE + 32'h8;
    localparam logic [31:0] A_STAT = BASE + 32'hC;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CEN = 1'b0;
    logic        WEN = 1'b0;
    logic [31:0] ADDR = '0;
    logic [3:0]  BYTE_SEL = '0;
    logic [31:0] SDATA = '0;
    logic [31:0] LDATA;
    logic        IRQ;

    int errors = 0;
    int checks = 0;

    mmio_timer #(.BASE_ADDR(BASE), .PSC_W(8)) dut (
        .CLK(CLK), .RST(RST), .CEN(CEN), .WEN(WEN), .ADDR(ADDR),
        .BYTE_SEL(BYTE_SEL), .SDATA(SDATA), .LDATA(LDATA), .IRQ(IRQ)
    );

    always #50 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Stores are launched just after a falling edge and retire on the next one.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        CEN = 1'b1; WEN = 1'b1; ADDR = a; SDATA = d; BYTE_SEL = be;
        @(negedge CLK);
        CEN = 1'b0; WEN = 1'b0; ADDR = '0; SDATA = '0; BYTE_SEL = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        CEN = 1'b1; WEN = 1'b0; ADDR = a;
        #1;
        chk(tag, LDATA, exp);
        CEN = 1'b0; ADDR = '0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        // Reset state
        #20;
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        rd_chk("rst_count", A_CNT, 32'h0);
        rd_chk("rst_compare", A_CMP, 32'h0);
        rd_chk("rst_status", A_STAT, 32'h0);
        chk("rst_irq", {31'd0, IRQ}, 32'h0);
        step(1);
        RST = 1'b1;
        step(1);
        rd_chk("other_window", 32'h2000_0000, 32'h0);

        // One-shot compare, PRESCALE=0, IRQ enabled
        wr(A_CMP, 32'd5, 4'hF);
        rd_chk("cmp_rd", A_CMP, 32'd5);
        rd_chk("cmp_addr_lsb_ignored", BASE + 32'h9, 32'd5);
        wr(A_CTRL, 32'h0000_0005, 4'hF);
        rd_chk("ctrl_rd", A_CTRL, 32'h0000_0005);
        rd_chk("cnt_start", A_CNT, 32'd0);
        step(5);
        rd_chk("cnt_reach5", A_CNT, 32'd5);
        rd_chk("no_match_yet", A_STAT, 32'd0);
        chk("irq_low_before", {31'd0, IRQ}, 32'd0);
        step(1);
        rd_chk("match_set", A_STAT, 32'd1);
        chk("irq_high", {31'd0, IRQ}, 32'd1);
        rd_chk("cnt_continue6", A_CNT, 32'd6);
        wr(A_CTRL, 32'h0, 4'hF);
        rd_chk("cnt_stop_on_disable", A_CNT, 32'd6);
        wr(A_STAT, 32'h1, 4'b0001);
        rd_chk("w1c_clear", A_STAT, 32'd0);
        chk("irq_cleared", {31'd0, IRQ}, 32'd0);

        // Auto-reload with PRESCALE=3: counts 0,1,2,0 on every fourth cycle
        wr(A_CNT, 32'd0, 4'hF);
        wr(A_CMP, 32'd2, 4'hF);
        wr(A_CTRL, 32'h0000_0303, 4'hF);
        step(3);
        rd_chk("psc_hold0", A_CNT, 32'd0);
        step(1);
        rd_chk("psc_tick1", A_CNT, 32'd1);
        step(3);
        rd_chk("psc_hold1", A_CNT, 32'd1);
        step(1);
        rd_chk("psc_tick2", A_CNT, 32'd2);
        step(4);
        rd_chk("reload0", A_CNT, 32'd0);
        rd_chk("reload_match", A_STAT, 32'd1);
        chk("irq_masked", {31'd0, IRQ}, 32'd0);

        // W1C racing a new match: set wins; later W1C clears
        wr(A_STAT, 32'h1, 4'b0001);
        rd_chk("w1c_pre", A_STAT, 32'd0);
        step(10);
        rd_chk("pre_race_cnt", A_CNT, 32'd2);
        wr(A_STAT, 32'h1, 4'b0001);
        rd_chk("set_wins", A_STAT, 32'd1);
        rd_chk("race_reload", A_CNT, 32'd0);
        wr(A_STAT, 32'h0, 4'b0001);
        rd_chk("w1c_zero_data", A_STAT, 32'd1);
        wr(A_STAT, 32'h1, 4'b0001);
        rd_chk("w1c_quiet", A_STAT, 32'd0);
        chk("irq_quiet", {31'd0, IRQ}, 32'd0);
        wr(A_CTRL, 32'h0, 4'hF);

        // Modulo wrap without match, then byte store racing a tick
        wr(A_CNT, 32'hFFFF_FFFF, 4'hF);
        wr(A_CMP, 32'h10, 4'hF);
        wr(A_CTRL, 32'h0000_0001, 4'hF);
        rd_chk("pre_wrap", A_CNT, 32'hFFFF_FFFF);
        step(1);
        rd_chk("wrap0", A_CNT, 32'h0);
        rd_chk("wrap_no_match", A_STAT, 32'd0);
        wr(A_CNT, 32'h0000_AB00, 4'b0010);
        rd_chk("store_wins", A_CNT, 32'h0000_AB00);
        step(1);
        rd_chk("resume_inc", A_CNT, 32'h0000_AB01);

        // Build a live match, then reset mid-count
        wr(A_CTRL, 32'h0000_0005, 4'hF);
        wr(A_CMP, 32'h0000_AB04, 4'hF);
        step(2);
        rd_chk("pre_rst_match", A_STAT, 32'd1);
        rd_chk("pre_rst_cnt", A_CNT, 32'h0000_AB05);
        chk("pre_rst_irq", {31'd0, IRQ}, 32'd1);
        #10;
        RST = 1'b0;
        #1;
        chk("async_irq", {31'd0, IRQ}, 32'd0);
        rd_chk("async_count", A_CNT, 32'h0);
        rd_chk("async_status", A_STAT, 32'h0);
        rd_chk("async_ctrl", A_CTRL, 32'h0);
        rd_chk("async_compare", A_CMP, 32'h0);
        step(1);
        RST = 1'b1;
        step(3);
        rd_chk("post_rst_hold", A_CNT, 32'h0);
        chk("post_rst_irq", {31'd0, IRQ}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
